serial_adder_ctrl: RTL

Bit-serial adder controller that sequences a single full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start handshake, keeps the carry in a flip-flop between bit steps, and shifts the result into a register. It sits above the half/full adder cells as the scheduler that time-shares one full adder across a whole word.

---
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder scheduler.
// Time-shares one full-adder cell over two WIDTH-bit operands, one bit per
// clock, LSB first. Operands are captured on an accepted start, the carry is
// kept in a flip-flop between bit steps, and result bits enter the sum
// register at the MSB and shift right until the whole word has been built.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input. A start
// with sub=1 computes a - b by loading ~b and forcing the carry-in to 1.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             sub_w;
  logic             fa_s, fa_c;

  // Subtract request; tied off when the feature is compiled out.
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // The single shared full-adder cell, fed from the operand LSBs and the carry.
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Next-state logic: capture on start, one bit step per cycle in RUN.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch; combinational logic uses blocking '='.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub_w ? ~b : b;
          carry_d = sub_w ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          // Last bit: carry_q is the carry into the MSB, fa_c the carry out.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled at the same edge.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are registers or decodes of the state register only.
  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
